// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: byte stream in, validated frames and error pulses out.
// master = frame controller side, slave = byte source / frame consumer side.
interface uart_frame_ctrl_if #(
    parameter int MAX_LEN = 8
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [7:0]           frame_cmd;
    logic [3:0]           frame_len;
    logic [MAX_LEN*8-1:0] frame_payload;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 err_overrun;

    modport master (
        input  rx_data, rx_valid, frame_ready,
        output frame_valid, frame_cmd, frame_len, frame_payload,
        output err_chk, err_len, err_timeout, err_overrun
    );

    modport slave (
        output rx_data, rx_valid, frame_ready,
        input  frame_valid, frame_cmd, frame_len, frame_payload,
        input  err_chk, err_len, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts SYNC/CMD/LEN/payload/CHK frames in a UART byte stream
// and hands validated frames to the command layer over valid/ready.
module uart_frame_ctrl #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         BAUD          = 100000,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 8,
    parameter int         TIMEOUT_BYTES = 4
) (
    input logic              clk,
    input logic              rst,
    uart_frame_ctrl_if.master bus
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int TO_CYC   = TIMEOUT_BYTES * 10 * BAUD_DIV;
    localparam int TO_W     = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHECK
    } state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  cmd_q, cmd_d;
    logic [3:0]                  len_q, len_d;
    logic [3:0]                  idx_q, idx_d;
    logic [7:0]                  chk_q, chk_d;
    logic [MAX_LEN-1:0][7:0]     pay_q, pay_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic                        good;

    logic                        frame_valid_q, frame_valid_d;
    logic [7:0]                  frame_cmd_q, frame_cmd_d;
    logic [3:0]                  frame_len_q, frame_len_d;
    logic [MAX_LEN*8-1:0]        frame_payload_q, frame_payload_d;
    logic                        err_chk_q, err_chk_d;
    logic                        err_len_q, err_len_d;
    logic                        err_timeout_q, err_timeout_d;
    logic                        err_overrun_q, err_overrun_d;

    // Parser next state, inter-byte timeout and error pulse generation.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        pay_d         = pay_q;
        to_cnt_d      = '0;
        good          = 1'b0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        if (bus.rx_valid) begin
            unique case (state_q)
                S_HUNT: begin
                    if (bus.rx_data == SYNC_BYTE) state_d = S_CMD;
                end
                S_CMD: begin
                    cmd_d   = bus.rx_data;
                    chk_d   = bus.rx_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (bus.rx_data > MAX_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        len_d   = bus.rx_data[3:0];
                        chk_d   = chk_q ^ bus.rx_data;
                        idx_d   = '0;
                        state_d = (bus.rx_data == 8'h00) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) pay_d[i] = bus.rx_data;
                    end
                    chk_d = chk_q ^ bus.rx_data;
                    if (idx_q == len_q - 4'd1) begin
                        idx_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (bus.rx_data == chk_q) good = 1'b1;
                    else                      err_chk_d = 1'b1;
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end else if (state_q != S_HUNT) begin
            if (to_cnt_q == TO_LAST) begin
                err_timeout_d = 1'b1;
                state_d       = S_HUNT;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Output holding register: commit good frames, drop them on overrun.
    always_comb begin
        frame_valid_d   = frame_valid_q;
        frame_cmd_d     = frame_cmd_q;
        frame_len_d     = frame_len_q;
        frame_payload_d = frame_payload_q;
        err_overrun_d   = 1'b0;
        if (frame_valid_q && bus.frame_ready) frame_valid_d = 1'b0;
        if (good) begin
            if (!frame_valid_q || bus.frame_ready) begin
                frame_valid_d = 1'b1;
                frame_cmd_d   = cmd_q;
                frame_len_d   = len_q;
                for (int i = 0; i < MAX_LEN; i++) begin
                    frame_payload_d[8*i +: 8] = (4'(i) < len_q) ? pay_q[i] : 8'h00;
                end
            end else begin
                err_overrun_d = 1'b1;
            end
        end
    end

    // State, working buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_HUNT;
            cmd_q           <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            chk_q           <= '0;
            pay_q           <= '0;
            to_cnt_q        <= '0;
            frame_valid_q   <= 1'b0;
            frame_cmd_q     <= '0;
            frame_len_q     <= '0;
            frame_payload_q <= '0;
            err_chk_q       <= 1'b0;
            err_len_q       <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_overrun_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            chk_q           <= chk_d;
            pay_q           <= pay_d;
            to_cnt_q        <= to_cnt_d;
            frame_valid_q   <= frame_valid_d;
            frame_cmd_q     <= frame_cmd_d;
            frame_len_q     <= frame_len_d;
            frame_payload_q <= frame_payload_d;
            err_chk_q       <= err_chk_d;
            err_len_q       <= err_len_d;
            err_timeout_q   <= err_timeout_d;
            err_overrun_q   <= err_overrun_d;
        end
    end

    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_cmd     = frame_cmd_q;
    assign bus.frame_len     = frame_len_q;
    assign bus.frame_payload = frame_payload_q;
    assign bus.err_chk       = err_chk_q;
    assign bus.err_len       = err_len_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_overrun   = err_overrun_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frame scenarios plus random frames checked
// against expectations built from the frame format itself.
module tb_uart_frame_ctrl;
    localparam int MAX_LEN = 8;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic fv,
                              input logic [7:0] c, input logic [3:0] l,
                              input logic [63:0] p, input logic [3:0] e);
        check({tag, " valid"}, 64'(bus.frame_valid), 64'(fv));
        check({tag, " errs"}, 64'({bus.err_chk, bus.err_len,
                                   bus.err_timeout, bus.err_overrun}), 64'(e));
        if (fv) begin
            check({tag, " cmd"}, 64'(bus.frame_cmd), 64'(c));
            check({tag, " len"}, 64'(bus.frame_len), 64'(l));
            check({tag, " payload"}, 64'(bus.frame_payload), p);
        end
    endtask

    task automatic expect_zero(input string tag);
        check({tag, " valid"}, 64'(bus.frame_valid), 64'd0);
        check({tag, " cmd"}, 64'(bus.frame_cmd), 64'd0);
        check({tag, " len"}, 64'(bus.frame_len), 64'd0);
        check({tag, " payload"}, 64'(bus.frame_payload), 64'd0);
        check({tag, " errs"}, 64'({bus.err_chk, bus.err_len,
                                   bus.err_timeout, bus.err_overrun}), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    initial begin
        bq_t          q;
        logic [7:0]   cmd;
        logic [3:0]   len;
        logic [7:0]   chk;
        logic [7:0]   b;
        logic [63:0]  exp_pay;
        bit           bad;

        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.frame_ready = 1'b1;
        rst             = 1'b1;
        repeat (3) @(negedge clk);
        expect_zero("reset");
        rst = 1'b0;

        // good frame with leading junk
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h12, 8'h02, 8'h34, 8'h56});
        check("t1 pre valid", 64'(bus.frame_valid), 64'd0);
        send_byte(8'h72);
        expect_out("t1", 1'b1, 8'h12, 4'd2, 64'h5634, 4'b0000);
        @(negedge clk);
        check("t1 cleared", 64'(bus.frame_valid), 64'd0);

        // zero-length frame
        send_seq('{8'hA5, 8'h01, 8'h00});
        send_byte(8'h01);
        expect_out("t2", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0000);
        @(negedge clk);

        // bad checksum, then recovery
        send_seq('{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56});
        send_byte(8'h00);
        expect_out("t3 bad", 1'b0, 8'h0, 4'd0, 64'h0, 4'b1000);
        @(negedge clk);
        check("t3 pulse", 64'(bus.err_chk), 64'd0);
        send_seq('{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56});
        send_byte(8'h72);
        expect_out("t3 good", 1'b1, 8'h12, 4'd2, 64'h5634, 4'b0000);
        @(negedge clk);

        // length error, then recovery
        send_seq('{8'hA5, 8'h12});
        send_byte(8'h09);
        expect_out("t4 len", 1'b0, 8'h0, 4'd0, 64'h0, 4'b0100);
        send_seq('{8'hA5, 8'h01, 8'h00});
        send_byte(8'h01);
        expect_out("t4 good", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0000);
        @(negedge clk);

        // timeout exactly 20000 clk after the CMD strobe
        send_seq('{8'hA5, 8'h12});
        repeat (19999) @(negedge clk);
        check("t5 early", 64'(bus.err_timeout), 64'd0);
        @(negedge clk);
        expect_out("t5 expire", 1'b0, 8'h0, 4'd0, 64'h0, 4'b0010);
        @(negedge clk);
        check("t5 pulse", 64'(bus.err_timeout), 64'd0);
        send_seq('{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56});
        send_byte(8'h72);
        expect_out("t5 good", 1'b1, 8'h12, 4'd2, 64'h5634, 4'b0000);
        @(negedge clk);

        // byte arriving on the expiry cycle wins
        send_seq('{8'hA5, 8'h12});
        repeat (19998) @(negedge clk);
        send_byte(8'h00);
        check("t5 race", 64'(bus.err_timeout), 64'd0);
        send_byte(8'h12);
        expect_out("t5 race frame", 1'b1, 8'h12, 4'd0, 64'h0, 4'b0000);
        @(negedge clk);

        // random frames against the frame-format model
        for (int k = 0; k < 40; k++) begin
            q = {};
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(8'hA5);
            cmd = 8'($urandom);
            len = 4'($urandom_range(0, MAX_LEN));
            q.push_back(cmd);
            q.push_back({4'h0, len});
            chk     = cmd ^ {4'h0, len};
            exp_pay = '0;
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom);
                q.push_back(b);
                chk = chk ^ b;
                exp_pay[8*i +: 8] = b;
            end
            bad = ($urandom_range(0, 3) == 0);
            if (bad) chk = chk ^ 8'($urandom_range(1, 255));
            send_seq(q);
            check("rand pre valid", 64'(bus.frame_valid), 64'd0);
            send_byte(chk);
            if (bad) expect_out("rand bad", 1'b0, 8'h0, 4'd0, 64'h0, 4'b1000);
            else     expect_out("rand good", 1'b1, cmd, len, exp_pay, 4'b0000);
            @(negedge clk);
        end

        // overrun: first frame held, second dropped
        bus.frame_ready = 1'b0;
        send_seq('{8'hA5, 8'h01, 8'h00});
        send_byte(8'h01);
        expect_out("t6 first", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0000);
        send_seq('{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56});
        send_byte(8'h72);
        expect_out("t6 overrun", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0001);
        @(negedge clk);
        expect_out("t6 held", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0000);

        // acceptance and commit in the same cycle
        send_seq('{8'hA5, 8'h33, 8'h01, 8'h44});
        @(negedge clk);
        bus.rx_data     = 8'h76;
        bus.rx_valid    = 1'b1;
        bus.frame_ready = 1'b1;
        @(negedge clk);
        bus.rx_valid    = 1'b0;
        bus.frame_ready = 1'b0;
        expect_out("t6 swap", 1'b1, 8'h33, 4'd1, 64'h44, 4'b0000);

        // reset mid-payload
        send_seq('{8'hA5, 8'h12, 8'h02, 8'h34});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_zero("t6 rst");
        rst = 1'b0;
        send_seq('{8'h56, 8'h72});
        expect_out("t6 hunt", 1'b0, 8'h0, 4'd0, 64'h0, 4'b0000);
        bus.frame_ready = 1'b1;
        send_seq('{8'hA5, 8'h01, 8'h00});
        send_byte(8'h01);
        expect_out("t6 after rst", 1'b1, 8'h01, 4'd0, 64'h0, 4'b0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
